// File: rtl/rr_mux_arbiter_pkg.sv
// Shared defaults and helpers for the round-robin mux arbiter.
// rotate_left works on a fixed MAX_REQ-wide container so every width up to MAX_REQ can share it.
package rr_mux_arbiter_pkg;

    localparam int DEFAULT_N_REQ = 4;
    localparam int DEFAULT_W     = 8;
    localparam int MAX_REQ       = 32;
    localparam int MAX_IW        = $clog2(MAX_REQ);

    // Rotate the low 'width' bits of vec left by 'amount'; bits at or above 'width' come back zero.
    function automatic logic [MAX_REQ-1:0] rotate_left(
        input logic [MAX_REQ-1:0] vec,
        input int                 amount,
        input int                 width
    );
        logic [MAX_REQ-1:0] res;
        res = '0;
        for (int i = 0; i < MAX_REQ; i++) begin
            if (i < width) begin
                res[MAX_IW'((i + amount) % width)] = vec[i[MAX_IW-1:0]];
            end
        end
        return res;
    endfunction

endpackage

// File: rtl/rr_priority_pick.sv
// Combinational round-robin pick: the first set request at or after ptr, wrapping around.
// Yields a one-hot grant, the binary index of the winner and an any-request flag.
module rr_priority_pick
    import rr_mux_arbiter_pkg::*;
#(
    parameter int  N_REQ = DEFAULT_N_REQ,
    localparam int IW    = $clog2(N_REQ)
) (
    input  logic [N_REQ-1:0] req,
    input  logic [IW-1:0]    ptr,
    output logic [N_REQ-1:0] grant,
    output logic [IW-1:0]    idx,
    output logic             any_grant
);

    logic [N_REQ-1:0] rot_req;
    logic [N_REQ-1:0] rot_low;

    // Rotate so that ptr lands on bit 0, isolate the lowest set bit, then rotate back.
    always_comb begin
        rot_req = N_REQ'(rotate_left(MAX_REQ'(req), N_REQ - int'(ptr), N_REQ));
        rot_low = rot_req & (~rot_req + N_REQ'(1));
        grant   = N_REQ'(rotate_left(MAX_REQ'(rot_low), int'(ptr), N_REQ));
    end

    for (genvar b = 0; b < IW; b++) begin : g_enc
        logic [N_REQ-1:0] mask;
        for (genvar r = 0; r < N_REQ; r++) begin : g_mask
            assign mask[r] = 1'((r >> b) & 1);
        end
        assign idx[b] = |(grant & mask);
    end

    assign any_grant = |req;

endmodule

// File: rtl/rr_mux_arbiter.sv
// N:1 round-robin arbiter feeding a one-entry registered output stage with valid/ready.
// The pointer advances past the winner only when a grant is actually accepted.
module rr_mux_arbiter
    import rr_mux_arbiter_pkg::*;
#(
    parameter int  N_REQ = DEFAULT_N_REQ,
    parameter int  W     = DEFAULT_W,
    localparam int IW    = $clog2(N_REQ)
) (
    input  logic               clk,
    input  logic               rst,
    input  logic [N_REQ-1:0]   req_vld,
    input  logic [N_REQ*W-1:0] req_data,
    output logic [N_REQ-1:0]   req_rdy,
    output logic               out_vld,
    output logic [W-1:0]       out_data,
    output logic [IW-1:0]      out_src,
    input  logic               out_rdy
);

    logic               out_vld_q,  out_vld_d;
    logic [W-1:0]       out_data_q, out_data_d;
    logic [IW-1:0]      out_src_q,  out_src_d;
    logic [IW-1:0]      ptr_q,      ptr_d;

    logic [N_REQ-1:0]          grant;
    logic [IW-1:0]             win_idx;
    logic                      any_grant;
    logic                      can_load;
    logic                      accept;
    logic [W-1:0]              sel_data;
    logic [W-1:0][N_REQ-1:0]   sel_cols;

    rr_priority_pick #(.N_REQ(N_REQ)) u_pick (
        .req       (req_vld),
        .ptr       (ptr_q),
        .grant     (grant),
        .idx       (win_idx),
        .any_grant (any_grant)
    );

    // AND-OR data mux on the one-hot grant, one column of requester bits per output bit.
    for (genvar b = 0; b < W; b++) begin : g_mux_bit
        for (genvar g = 0; g < N_REQ; g++) begin : g_mux_req
            assign sel_cols[b][g] = req_data[g*W + b] & grant[g];
        end
        assign sel_data[b] = |sel_cols[b];
    end

    always_comb begin
        can_load = !out_vld_q || out_rdy;
        accept   = any_grant && can_load;
        req_rdy  = rst ? '0 : (grant & {N_REQ{can_load}});
    end

    always_comb begin
        out_vld_d  = out_vld_q;
        out_data_d = out_data_q;
        out_src_d  = out_src_q;
        ptr_d      = ptr_q;
        if (accept) begin
            out_vld_d  = 1'b1;
            out_data_d = sel_data;
            out_src_d  = win_idx;
            ptr_d      = win_idx + IW'(1);
        end else if (out_vld_q && out_rdy) begin
            out_vld_d  = 1'b0;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            out_vld_q  <= 1'b0;
            out_data_q <= '0;
            out_src_q  <= '0;
            ptr_q      <= '0;
        end else begin
            out_vld_q  <= out_vld_d;
            out_data_q <= out_data_d;
            out_src_q  <= out_src_d;
            ptr_q      <= ptr_d;
        end
    end

    assign out_vld  = out_vld_q;
    assign out_data = out_data_q;
    assign out_src  = out_src_q;

endmodule

// File: tb/tb_rr_mux_arbiter.sv
// Directed and randomised bench for rr_mux_arbiter with a spec-level model,
// a per-requester FIFO scoreboard and a starvation counter.
module tb_rr_mux_arbiter;

    localparam int N = 4;
    localparam int W = 8;

    logic             clk = 1'b0;
    logic             rst;
    logic [N-1:0]     req_vld;
    logic [N*W-1:0]   req_data;
    logic [N-1:0]     req_rdy;
    logic             out_vld;
    logic [W-1:0]     out_data;
    logic [1:0]       out_src;
    logic             out_rdy;

    int checks = 0;
    int passes = 0;

    bit           model_live = 1'b0;
    bit           m_vld      = 1'b0;
    int           m_data     = 0;
    int           m_src      = 0;
    int           m_ptr      = 0;
    logic [N-1:0] acc_mask   = '0;
    int           sb_q [N][$];
    int           wait_cnt [N];

    rr_mux_arbiter #(.N_REQ(N), .W(W)) dut (
        .clk      (clk),
        .rst      (rst),
        .req_vld  (req_vld),
        .req_data (req_data),
        .req_rdy  (req_rdy),
        .out_vld  (out_vld),
        .out_data (out_data),
        .out_src  (out_src),
        .out_rdy  (out_rdy)
    );

    always #5 clk = ~clk;

    function automatic int find_winner(input int vld, input int ptr);
        for (int k = 0; k < N; k++) begin
            if (((vld >> ((ptr + k) % N)) & 1) == 1) return (ptr + k) % N;
        end
        return -1;
    endfunction

    task automatic checkOutput(input string name, input int actual, input int expected);
        checks++;
        if (actual == expected) begin
            passes++;
        end else begin
            $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h at %0t", name, actual, expected, $time);
        end
    endtask

    task automatic applyStimulus(input logic [N-1:0] vld, input logic [N*W-1:0] data,
                                 input logic rdy, input logic r);
        @(posedge clk);
        #1;
        req_vld  = vld;
        req_data = data;
        out_rdy  = rdy;
        rst      = r;
    endtask

    // Inputs are stable from posedge+1 to the next posedge, so at negedge the model
    // can both check the current cycle and compute what the coming edge must do.
    always @(negedge clk) begin : compare
        int vld_i;
        int rdy_i;
        int data_i;
        int win;
        int exp_rdy;
        int s;
        bit can_load;
        vld_i    = int'(req_vld);
        rdy_i    = int'(req_rdy);
        data_i   = int'(req_data);
        can_load = !m_vld || (out_rdy == 1'b1);
        win      = find_winner(vld_i, m_ptr);
        exp_rdy  = (rst || win < 0 || !can_load) ? 0 : (1 << win);
        if (model_live) begin
            checkOutput("req_rdy", rdy_i, exp_rdy);
            checkOutput("out_vld", int'(out_vld), int'(m_vld));
            checkOutput("out_data", int'(out_data), m_data);
            checkOutput("out_src", int'(out_src), m_src);
            if (!rst) begin
                if (out_vld && out_rdy) begin
                    s = int'(out_src);
                    checkOutput("sb_nonempty", int'(sb_q[s].size() > 0), 1);
                    if (sb_q[s].size() > 0) checkOutput("sb_order", int'(out_data), sb_q[s].pop_front());
                end
                for (int i = 0; i < N; i++) begin
                    if ((((rdy_i & vld_i) >> i) & 1) == 1) sb_q[i].push_back((data_i >> (W*i)) & 255);
                    if (((vld_i >> i) & 1) == 0) begin
                        wait_cnt[i] = 0;
                    end else if ((rdy_i & vld_i) != 0) begin
                        if (((rdy_i >> i) & 1) == 1) begin
                            wait_cnt[i] = 0;
                        end else begin
                            wait_cnt[i]++;
                            checkOutput("fair_wait", int'(wait_cnt[i] < N), 1);
                        end
                    end
                end
            end
        end
        acc_mask = req_vld & req_rdy;
        if (rst) begin
            m_vld      = 1'b0;
            m_data     = 0;
            m_src      = 0;
            m_ptr      = 0;
            model_live = 1'b1;
            for (int i = 0; i < N; i++) begin
                sb_q[i].delete();
                wait_cnt[i] = 0;
            end
        end else if (win >= 0 && can_load) begin
            m_vld  = 1'b1;
            m_data = (data_i >> (W*win)) & 255;
            m_src  = win;
            m_ptr  = (win + 1) % N;
        end else if (m_vld && out_rdy) begin
            m_vld  = 1'b0;
        end
    end

    initial begin
        int pend [N];
        int seq  [N];
        int left;
        logic [N-1:0]   vld_v;
        logic [N*W-1:0] data_v;

        rst = 1'b1; req_vld = '0; req_data = '0; out_rdy = 1'b0;
        applyStimulus(4'b0000, 32'h0, 1'b0, 1'b1);
        applyStimulus(4'b0000, 32'h0, 1'b0, 1'b1);

        // All four requesters valid, consumer always ready: strict 0,1,2,3 rotation.
        applyStimulus(4'b1111, 32'h13121110, 1'b1, 1'b0);
        @(negedge clk);
        checkOutput("t2_rdy_first", int'(req_rdy), 1);
        checkOutput("t2_vld_first", int'(out_vld), 0);
        for (int k = 0; k < 5; k++) begin
            @(negedge clk);
            checkOutput("t2_src", int'(out_src), k % 4);
            checkOutput("t2_data", int'(out_data), 16 + (k % 4));
        end

        // Backpressure while requester 1's item sits in the output register.
        applyStimulus(4'b1111, 32'h13121110, 1'b0, 1'b0);
        for (int k = 0; k < 5; k++) begin
            @(negedge clk);
            checkOutput("t4_rdy_hold", int'(req_rdy), 0);
            checkOutput("t4_src_hold", int'(out_src), 1);
            checkOutput("t4_data_hold", int'(out_data), 8'h11);
        end
        applyStimulus(4'b1111, 32'h13121110, 1'b1, 1'b0);
        @(negedge clk);
        checkOutput("t4_rdy_release", int'(req_rdy), 4'b0100);
        @(negedge clk);
        checkOutput("t4_src_release", int'(out_src), 2);
        checkOutput("t4_data_release", int'(out_data), 8'h12);

        // Lone requester 2.
        applyStimulus(4'b0100, 32'h00A50000, 1'b1, 1'b0);
        @(negedge clk);
        checkOutput("t3_rdy", int'(req_rdy), 4'b0100);
        for (int k = 0; k < 3; k++) begin
            @(negedge clk);
            checkOutput("t3_src", int'(out_src), 2);
            checkOutput("t3_data", int'(out_data), 8'hA5);
            checkOutput("t3_rdy_rep", int'(req_rdy), 4'b0100);
        end

        // Pointer sits at 3 and must wrap to requester 0.
        applyStimulus(4'b0011, 32'h00004140, 1'b1, 1'b0);
        @(negedge clk);
        checkOutput("t5_rdy_wrap", int'(req_rdy), 4'b0001);
        @(negedge clk);
        checkOutput("t5_src0", int'(out_src), 0);
        checkOutput("t5_data0", int'(out_data), 8'h40);
        checkOutput("t5_rdy1", int'(req_rdy), 4'b0010);
        @(negedge clk);
        checkOutput("t5_src1", int'(out_src), 1);
        checkOutput("t5_data1", int'(out_data), 8'h41);
        checkOutput("t5_rdy0", int'(req_rdy), 4'b0001);
        @(negedge clk);
        checkOutput("t5_src0_again", int'(out_src), 0);

        // Reset while a stalled item (0x33) is held; pointer is nonzero beforehand.
        applyStimulus(4'b0001, 32'h44444433, 1'b1, 1'b0);
        @(negedge clk);
        checkOutput("t1_rdy_pre", int'(req_rdy), 4'b0001);
        applyStimulus(4'b1111, 32'h44444433, 1'b0, 1'b1);
        @(negedge clk);
        checkOutput("t1_vld_held", int'(out_vld), 1);
        checkOutput("t1_data_held", int'(out_data), 8'h33);
        checkOutput("t1_rdy_in_rst", int'(req_rdy), 0);
        applyStimulus(4'b1111, 32'h44444433, 1'b1, 1'b0);
        @(negedge clk);
        checkOutput("t1_vld_after", int'(out_vld), 0);
        checkOutput("t1_data_after", int'(out_data), 0);
        checkOutput("t1_src_after", int'(out_src), 0);
        checkOutput("t1_rdy_after", int'(req_rdy), 4'b0001);
        @(negedge clk);
        checkOutput("t1_src_first", int'(out_src), 0);
        checkOutput("t1_data_first", int'(out_data), 8'h33);

        // Random producers that hold valid until accepted, random consumer stalls.
        for (int i = 0; i < N; i++) begin
            pend[i] = 0;
            seq[i]  = 0;
        end
        applyStimulus(4'b0000, 32'h0, 1'b1, 1'b0);
        for (int c = 0; c < 10000; c++) begin
            @(negedge clk);
            vld_v  = '0;
            data_v = '0;
            for (int i = 0; i < N; i++) begin
                if (pend[i] == 1 && ((int'(acc_mask) >> i) & 1) == 1) begin
                    pend[i] = 0;
                    seq[i]  = (seq[i] + 1) % 64;
                end
                if (pend[i] == 0 && $urandom_range(0, 1) == 1) pend[i] = 1;
                vld_v  = vld_v | N'(pend[i] << i);
                data_v = data_v | 32'(((i << 6) | seq[i]) << (W*i));
            end
            applyStimulus(vld_v, data_v, 1'($urandom_range(0, 9) < 7), 1'b0);
        end

        // Drain: nothing accepted may remain unaccounted for.
        applyStimulus(4'b0000, 32'h0, 1'b1, 1'b0);
        applyStimulus(4'b0000, 32'h0, 1'b1, 1'b0);
        applyStimulus(4'b0000, 32'h0, 1'b1, 1'b0);
        @(negedge clk);
        left = 0;
        for (int i = 0; i < N; i++) left += sb_q[i].size();
        checkOutput("sb_leftover", left, 0);

        $display("%0d/%0d checks passed", passes, checks);
        $finish;
    end

endmodule

// File: doc/rr_mux_arbiter.md
Name: rr_mux_arbiter

Overview:
- Shares one output channel among N_REQ requesters through a registered N:1 data mux.
- A round-robin arbiter drives the mux select and issues per-requester ready.
- Output is a one-entry registered stage with a valid/ready handshake, placed between independent producers and a single consumer.

Parameters:
- N_REQ, 4, number of requesters; must be ≥2 and a power of 2.
- W, 8, data width per requester.
- IW, $clog2(N_REQ), derived index width; must not be overridden.

Ports:
- clk, input, 1, clock; all state updates on its rising edge.
- rst, input, 1, synchronous active-high reset.
- req_vld, input, N_REQ, per-requester valid.
- req_data, input, N_REQ*W, flattened data; requester i occupies bits [i*W +: W].
- req_rdy, output, N_REQ, per-requester ready; at most one bit is set.
- out_vld, output, 1, output register holds valid data.
- out_data, output, W, registered data.
- out_src, output, IW, index of the requester that supplied out_data.
- out_rdy, input, 1, consumer accepts out_data when out_vld is also high.

Behaviour:
- Reset (rst high at a clk edge): out_vld=0, out_data=0, out_src=0, priority pointer ptr=0. req_rdy is 0 while rst is high. rst has priority over any transfer in the same cycle; an item held in the output register is dropped.
- Transfers:
  - Requester i transfers when req_vld[i] and req_rdy[i] are both high at a clk edge.
  - The output transfers when out_vld and out_rdy are both high at a clk edge.
- can_load = !out_vld || out_rdy, combinational.
- Grant (combinational):
  - Search req_vld starting at index ptr, ascending, wrapping from N_REQ-1 to 0.
  - The first set bit wins: grant is one-hot, or zero if no requester is valid.
  - req_rdy = grant & {N_REQ{can_load}}.
- req_rdy depends combinationally on req_vld and out_rdy. Requesters must not make req_vld depend on req_rdy.
- Load: if a grant is accepted on a clk edge, then on that edge:
  - out_data ← req_data of the winner.
  - out_src ← winner index.
  - out_vld ← 1.
  - ptr ← (winner+1) mod N_REQ.
- Drain: if the output transfers and no grant is accepted on the same edge, out_vld ← 0. out_data and out_src keep their values.
- Simultaneous drain and load on one edge: the new item replaces the old one, out_vld stays 1, throughput is 1 item/cycle.
- Hold: if out_vld=1 and out_rdy=0, req_rdy is all-zero. out_data, out_src and ptr are frozen.
- ptr changes only on an accepted grant. Idle cycles and stalled cycles leave it unchanged.
- Latency: data accepted at edge k is presented on out_data immediately after edge k, i.e. visible in cycle k+1.
- Fairness: a requester holding req_vld continuously is granted within N_REQ accepted grants. No requester is starved under any out_rdy pattern that accepts infinitely often.
- Requester-side stability is the producer's duty: while req_vld[i]=1 and req_rdy[i]=0, req_data[i] stays stable. The block does not check this.
- The block creates or drops no data except on reset. Order is preserved per requester.

Decomposition:
- Package rr_mux_arbiter_pkg:
  - Default N_REQ and W as localparams.
  - A function rotate_left(vec, amount) used by the grant search.
- Sub-module rr_priority_pick: purely combinational.
  - Inputs: req vector and ptr.
  - Outputs: one-hot grant, binary index, any_grant.
  - Implementation: rotate the request vector by ptr, take the lowest set bit, rotate back.
- Top level:
  - Output register and ptr register.
  - Data selection: an N:1 mux tree built from 2:1 mux instances indexed by the winner index, or an equivalent AND-OR on the one-hot grant.

Test Plan:
1. Reset mid-operation: out_vld=1 holding data 0x33, assert rst one cycle → next cycle out_vld=0, out_data=0, out_src=0, req_rdy=0 during rst; first grant afterwards goes to requester 0.
2. All four requesters valid with data 0x10/0x11/0x12/0x13, out_rdy=1 constantly → out_src sequence 0,1,2,3,0,1..., one item per cycle, out_data matches source.
3. Only requester 2 valid (data 0xA5), out_rdy=1 → req_rdy=4'b0100 every cycle; out_data=0xA5, out_src=2 one cycle after each accept; ptr rests at 3.
4. Backpressure: out_vld=1, out_src=1, out_rdy=0 for 5 cycles with all req_vld=1 → req_rdy=0 throughout, out_data frozen; on out_rdy=1 requester 2 is granted the same cycle and out_src=2 on the next cycle.
5. Wrap-around: ptr=3, req_vld=4'b0011 → requester 0 granted, then requester 1, then requester 0 again.
6. Random requests and random out_rdy for 10k cycles against a per-requester FIFO scoreboard → no loss, no duplicates, per-source order kept, every waiting requester served within 4 accepted grants.
